pic_alu_gen2: RTL and testbench
===============================

// Module: pic_alu_gen2
// PURPOSE
//  Parametrised second-generation PIC-class ALU: owns W and STATUS C/DC/Z, executes the
//  byte/bit/literal instruction set with full flag semantics, and registers results.
//  Sits between decode and the file-register port; valid/ready on issue, single-cycle result.
//  Adds what gen1 lacked: C/DC arithmetic, f-W subtract, external STATUS load, and an
//  optional iterative multiplier.
// PARAMETERS
//  DWIDTH          8                 data width; multiple of 4, >= 8
//  L2_DWIDTH       $clog2(DWIDTH)    bit-select width
//  ALU_INST_WIDTH  5                 opcode width; opcode encodings from pic_params package
// PORTS
//  clk                 in   1                  clock
//  rst                 in   1                  reset, synchronous, active-high
//  op_valid            in   1                  instruction presented this cycle
//  op_ready            out  1                  ALU can accept (low only while multiply busy)
//  alu_instruction     in   ALU_INST_WIDTH     opcode
//  bit_num             in   L2_DWIDTH          bit index for BCF/BSF/BTFSC/BTFSS
//  literal_value       in   DWIDTH             literal operand
//  dest_bit            in   1                  1: result to f, 0: result to W
//  freg_i              in   DWIDTH             file-register operand
//  status_load         in   1                  core write to STATUS register
//  status_i            in   3                  {Z,DC,C} value for status_load
//  freg_o              out  DWIDTH             result for file write
//  freg_wen            out  1                  freg_o valid, write it
//  res_valid           out  1                  instruction retired this cycle
//  skip                out  1                  next instruction to be skipped
//  w_o                 out  DWIDTH             current W
//  status_carry / status_digit_carry / status_zero  out 1  flags
//  prod_o              out  2*DWIDTH           product (PIC_ALU_MULT_EN only)
// BEHAVIOUR
//  - Reset: W=0, C=DC=Z=0, freg_o=0, freg_wen=0, res_valid=0, skip=0, op_ready=1, prod_o=0.
//  - Accept when op_valid&&op_ready; all results/flags registered, latency 1 cycle.
//  - freg_wen/res_valid/skip are single-cycle pulses; 0 on cycles with no accept.
//  - freg_wen=dest_bit for ADDWF,ANDWF,COMF,DECF,DECFSZ,INCF,INCFSZ,IORWF,MOVF,RLF,RRF,
//    SUBWF,SWAPF,XORWF; =1 for BCF,BSF,CLRF,MOVWF; else 0.
//  - Arithmetic at DWIDTH+1 bits. ADDWF: R=W+f, C=carry out, DC=carry out of bit 3.
//  - SUBWF: R=f-W (f + ~W + 1), C=1 when no borrow (f>=W), DC=1 when no nibble borrow.
//  - Z=(R==0) for ADDWF,SUBWF,ANDWF,IORWF,XORWF,ANDLW,IORLW,XORLW,COMF,DECF,INCF,MOVF
//    (MOVF sets Z for either dest); CLRF/CLRW force Z=1.
//  - DECFSZ/INCFSZ: Z untouched; skip=1 when R==0. BTFSC skip when bit 0; BTFSS when bit 1.
//  - RLF/RRF rotate through C; old C enters, shifted-out bit becomes new C.
//  - SWAPF exchanges upper and lower DWIDTH/2 halves.
//  - Unlisted opcodes (NOP etc.): res_valid=1, no state change.
//  - status_load same cycle as a flag-writing instruction: instruction's flags win for
//    flags it writes; status_i applies to the rest.
//  - W and freg_o updated only by the listed instructions; freg_o holds otherwise.
// CONFIGURATION
//  - PIC_ALU_MULT_EN defined: MULWF opcode enabled. FSM IDLE->MUL (DWIDTH cycles,
//    shift-add, op_ready=0)->DONE (prod_o=W*f unsigned, res_valid=1, flags unchanged)->IDLE.
//    Operands captured at accept; status_load during MUL still applies; rst in MUL aborts,
//    prod_o=0.
//  - Undefined: MULWF treated as unlisted opcode; op_ready tied 1; prod_o tied 0; no FSM.
// STRUCTURE
//  - pic_params package: opcode localparams (incl. MULWF), ALU_INST_WIDTH, STATUS bit
//    indices, mult FSM state encoding.
//  - One sub-module: pic_alu_mul (iterative shift-add multiplier, start/done), instantiated
//    only under PIC_ALU_MULT_EN.
// TESTING
//  - MOVLW 0x0F; ADDWF f=0x01,d=0 -> W=0x10, C=0, DC=1, Z=0, freg_wen=0.
//  - MOVLW 0x01; SUBWF f=0x01,d=1 -> freg_o=0x00, freg_wen=1, Z=1, C=1, DC=1.
//  - MOVLW 0x02; SUBWF f=0x01,d=0 -> W=0xFF, C=0, DC=0, Z=0.
//  - C=1; RRF f=0x02,d=1 -> freg_o=0x81, C=0; DECFSZ f=0x01 -> skip=1, Z unchanged.
//  - status_load {Z,DC,C}=3'b111 with ANDLW giving non-zero -> Z=0, DC=1, C=1.
//  - MULT_EN: W=0xFF, MULWF f=0xFF -> op_ready=0 for 8 cycles, prod_o=0xFE01, res_valid
//    pulse; rst mid-multiply -> op_ready=1, prod_o=0 next cycle.

Source files
------------

// File: rtl/pic_params.sv
// pic_params: opcodes, STATUS bit indices and multiplier FSM states
// shared by the PIC ALU slice (MULWF is used only with PIC_ALU_MULT_EN).
package pic_params;

  localparam int ALU_INST_WIDTH = 5;

  localparam logic [ALU_INST_WIDTH-1:0] OP_NOP    = 5'd0;
  localparam logic [ALU_INST_WIDTH-1:0] OP_ADDWF  = 5'd1;
  localparam logic [ALU_INST_WIDTH-1:0] OP_ANDWF  = 5'd2;
  localparam logic [ALU_INST_WIDTH-1:0] OP_CLRF   = 5'd3;
  localparam logic [ALU_INST_WIDTH-1:0] OP_CLRW   = 5'd4;
  localparam logic [ALU_INST_WIDTH-1:0] OP_COMF   = 5'd5;
  localparam logic [ALU_INST_WIDTH-1:0] OP_DECF   = 5'd6;
  localparam logic [ALU_INST_WIDTH-1:0] OP_DECFSZ = 5'd7;
  localparam logic [ALU_INST_WIDTH-1:0] OP_INCF   = 5'd8;
  localparam logic [ALU_INST_WIDTH-1:0] OP_INCFSZ = 5'd9;
  localparam logic [ALU_INST_WIDTH-1:0] OP_IORWF  = 5'd10;
  localparam logic [ALU_INST_WIDTH-1:0] OP_MOVF   = 5'd11;
  localparam logic [ALU_INST_WIDTH-1:0] OP_MOVWF  = 5'd12;
  localparam logic [ALU_INST_WIDTH-1:0] OP_RLF    = 5'd13;
  localparam logic [ALU_INST_WIDTH-1:0] OP_RRF    = 5'd14;
  localparam logic [ALU_INST_WIDTH-1:0] OP_SUBWF  = 5'd15;
  localparam logic [ALU_INST_WIDTH-1:0] OP_SWAPF  = 5'd16;
  localparam logic [ALU_INST_WIDTH-1:0] OP_XORWF  = 5'd17;
  localparam logic [ALU_INST_WIDTH-1:0] OP_BCF    = 5'd18;
  localparam logic [ALU_INST_WIDTH-1:0] OP_BSF    = 5'd19;
  localparam logic [ALU_INST_WIDTH-1:0] OP_BTFSC  = 5'd20;
  localparam logic [ALU_INST_WIDTH-1:0] OP_BTFSS  = 5'd21;
  localparam logic [ALU_INST_WIDTH-1:0] OP_ANDLW  = 5'd22;
  localparam logic [ALU_INST_WIDTH-1:0] OP_IORLW  = 5'd23;
  localparam logic [ALU_INST_WIDTH-1:0] OP_MOVLW  = 5'd24;
  localparam logic [ALU_INST_WIDTH-1:0] OP_XORLW  = 5'd25;
  localparam logic [ALU_INST_WIDTH-1:0] OP_MULWF  = 5'd26;

  localparam int ST_C  = 0;
  localparam int ST_DC = 1;
  localparam int ST_Z  = 2;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_MUL  = 2'd1,
    MS_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/pic_alu_gen2_if.sv
// pic_alu_gen2_if: issue / result bundle between decode and the ALU.
// master = decode/core side, slave = ALU side.
interface pic_alu_gen2_if
  import pic_params::*;
#(
  parameter int DWIDTH         = 8,
  parameter int L2_DWIDTH      = $clog2(DWIDTH),
  parameter int ALU_INST_WIDTH = pic_params::ALU_INST_WIDTH
);
  logic                      op_valid;
  logic                      op_ready;
  logic [ALU_INST_WIDTH-1:0] alu_instruction;
  logic [L2_DWIDTH-1:0]      bit_num;
  logic [DWIDTH-1:0]         literal_value;
  logic                      dest_bit;
  logic [DWIDTH-1:0]         freg_i;
  logic                      status_load;
  logic [2:0]                status_i;
  logic [DWIDTH-1:0]         freg_o;
  logic                      freg_wen;
  logic                      res_valid;
  logic                      skip;
  logic [DWIDTH-1:0]         w_o;
  logic                      status_carry;
  logic                      status_digit_carry;
  logic                      status_zero;
  logic [2*DWIDTH-1:0]       prod_o;

  modport master (
    output op_valid, alu_instruction, bit_num,
    output literal_value, dest_bit, freg_i,
    output status_load, status_i,
    input  op_ready, freg_o, freg_wen, res_valid,
    input  skip, w_o, status_carry,
    input  status_digit_carry, status_zero, prod_o
  );

  modport slave (
    input  op_valid, alu_instruction, bit_num,
    input  literal_value, dest_bit, freg_i,
    input  status_load, status_i,
    output op_ready, freg_o, freg_wen, res_valid,
    output skip, w_o, status_carry,
    output status_digit_carry, status_zero, prod_o
  );
endinterface

// File: rtl/pic_alu_mul.sv
// pic_alu_mul: iterative unsigned shift-add multiplier, one partial
// product per cycle; o_done flags the cycle whose edge finishes it.
module pic_alu_mul #(
  parameter int DWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [DWIDTH-1:0]   i_a,
  input  logic [DWIDTH-1:0]   i_b,
  output logic                o_done,
  output logic [2*DWIDTH-1:0] o_prod
);
  localparam int CW = $clog2(DWIDTH + 1);

  logic [2*DWIDTH-1:0] r_acc;
  logic [2*DWIDTH-1:0] r_mcand;
  logic [DWIDTH-1:0]   r_mplier;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic [2*DWIDTH-1:0] w_acc_n;

  assign w_acc_n = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign o_done  = r_busy && (r_cnt == CW'(1));
  assign o_prod  = w_acc_n;

  // load operands on start, then add/shift once per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DWIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= CW'(DWIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_n;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/pic_alu_gen2.sv
// pic_alu_gen2: PIC-class ALU owning W and STATUS C/DC/Z, 1-cycle result.
// Define PIC_ALU_MULT_EN to enable MULWF via the pic_alu_mul FSM.
module pic_alu_gen2
  import pic_params::*;
#(
  parameter int DWIDTH         = 8,
  parameter int L2_DWIDTH      = $clog2(DWIDTH),
  parameter int ALU_INST_WIDTH = pic_params::ALU_INST_WIDTH
) (
  input logic           clk,
  input logic           rst,
  pic_alu_gen2_if.slave bus
);
  localparam int HW = DWIDTH / 2;

  logic [ALU_INST_WIDTH-1:0] w_op;
  logic [L2_DWIDTH-1:0]      w_bit;
  logic [DWIDTH-1:0]         w_f, w_lit, w_mask, w_res;
  logic [DWIDTH-1:0]         w_dec, w_inc;
  logic [DWIDTH:0]           w_add, w_sub;
  logic [4:0]                w_add_n, w_sub_n;
  logic w_acc, w_acc_alu, w_rdy, w_is_mul, w_mul_ret;
  logic w_dsel, w_to_w, w_to_f, w_skip, w_zr;
  logic w_c_we, w_dc_we, w_z_we, w_c, w_dc, w_z;

  logic [DWIDTH-1:0] r_w, r_freg;
  logic r_c, r_dc, r_z, r_wen, r_rv, r_skip;

  assign w_op    = bus.alu_instruction;
  assign w_bit   = bus.bit_num;
  assign w_f     = bus.freg_i;
  assign w_lit   = bus.literal_value;
  assign w_mask  = {{(DWIDTH-1){1'b0}}, 1'b1} << w_bit;
  assign w_dec   = w_f - DWIDTH'(1);
  assign w_inc   = w_f + DWIDTH'(1);
  assign w_add   = {1'b0, r_w} + {1'b0, w_f};
  assign w_sub   = {1'b0, w_f} + {1'b0, ~r_w} + (DWIDTH+1)'(1);
  assign w_add_n = {1'b0, r_w[3:0]} + {1'b0, w_f[3:0]};
  assign w_sub_n = {1'b0, w_f[3:0]} + {1'b0, ~r_w[3:0]} + 5'd1;
  assign w_zr    = (w_res == '0);
  assign w_acc     = bus.op_valid && w_rdy;
  assign w_acc_alu = w_acc && !w_is_mul;

  // decode: result, destination and which flags this opcode writes
  always_comb begin
    w_res = '0;
    w_dsel = 1'b0; w_to_w = 1'b0; w_to_f = 1'b0;
    w_skip = 1'b0; w_c = r_c; w_dc = r_dc; w_z = 1'b0;
    w_c_we = 1'b0; w_dc_we = 1'b0; w_z_we = 1'b0;
    unique case (1'b1)
      (w_op == OP_ADDWF): begin
        w_res = w_add[DWIDTH-1:0];
        w_c = w_add[DWIDTH]; w_dc = w_add_n[4];
        w_dsel = 1'b1; w_c_we = 1'b1;
        w_dc_we = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_SUBWF): begin
        w_res = w_sub[DWIDTH-1:0];
        w_c = w_sub[DWIDTH]; w_dc = w_sub_n[4];
        w_dsel = 1'b1; w_c_we = 1'b1;
        w_dc_we = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_ANDWF): begin
        w_res = r_w & w_f; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_IORWF): begin
        w_res = r_w | w_f; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_XORWF): begin
        w_res = r_w ^ w_f; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_COMF): begin
        w_res = ~w_f; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_DECF): begin
        w_res = w_dec; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_INCF): begin
        w_res = w_inc; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_MOVF): begin
        w_res = w_f; w_dsel = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_DECFSZ): begin
        w_res = w_dec; w_dsel = 1'b1; w_skip = (w_dec == '0);
      end
      (w_op == OP_INCFSZ): begin
        w_res = w_inc; w_dsel = 1'b1; w_skip = (w_inc == '0);
      end
      (w_op == OP_RLF): begin
        w_res = {w_f[DWIDTH-2:0], r_c};
        w_c = w_f[DWIDTH-1]; w_c_we = 1'b1; w_dsel = 1'b1;
      end
      (w_op == OP_RRF): begin
        w_res = {r_c, w_f[DWIDTH-1:1]};
        w_c = w_f[0]; w_c_we = 1'b1; w_dsel = 1'b1;
      end
      (w_op == OP_SWAPF): begin
        w_res = {w_f[HW-1:0], w_f[DWIDTH-1:HW]}; w_dsel = 1'b1;
      end
      (w_op == OP_CLRF): begin
        w_to_f = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_CLRW): begin
        w_to_w = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_MOVWF): begin
        w_res = r_w; w_to_f = 1'b1;
      end
      (w_op == OP_BCF): begin
        w_res = w_f & ~w_mask; w_to_f = 1'b1;
      end
      (w_op == OP_BSF): begin
        w_res = w_f | w_mask; w_to_f = 1'b1;
      end
      (w_op == OP_BTFSC): w_skip = ~|(w_f & w_mask);
      (w_op == OP_BTFSS): w_skip = |(w_f & w_mask);
      (w_op == OP_ANDLW): begin
        w_res = r_w & w_lit; w_to_w = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_IORLW): begin
        w_res = r_w | w_lit; w_to_w = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_XORLW): begin
        w_res = r_w ^ w_lit; w_to_w = 1'b1; w_z_we = 1'b1;
      end
      (w_op == OP_MOVLW): begin
        w_res = w_lit; w_to_w = 1'b1;
      end
      default: ;
    endcase
    if (w_dsel) begin
      w_to_f = bus.dest_bit;
      w_to_w = !bus.dest_bit;
    end
    w_z = w_zr;
  end

  // architectural state, flags and single-cycle result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w <= '0; r_freg <= '0;
      r_c <= 1'b0; r_dc <= 1'b0; r_z <= 1'b0;
      r_wen <= 1'b0; r_rv <= 1'b0; r_skip <= 1'b0;
    end else begin
      r_wen  <= w_acc_alu && w_to_f;
      r_rv   <= w_acc_alu || w_mul_ret;
      r_skip <= w_acc_alu && w_skip;
      if (w_acc_alu && w_to_w) r_w <= w_res;
      if (w_acc_alu && w_to_f) r_freg <= w_res;
      if (w_acc_alu && w_c_we) r_c <= w_c;
      else if (bus.status_load) r_c <= bus.status_i[ST_C];
      if (w_acc_alu && w_dc_we) r_dc <= w_dc;
      else if (bus.status_load) r_dc <= bus.status_i[ST_DC];
      if (w_acc_alu && w_z_we) r_z <= w_z;
      else if (bus.status_load) r_z <= bus.status_i[ST_Z];
    end
  end

`ifdef PIC_ALU_MULT_EN
  mul_state_t          r_ms, w_ms_n;
  logic                w_mul_start, w_mul_done;
  logic [2*DWIDTH-1:0] w_mul_prod, r_prod;

  assign w_is_mul  = (w_op == OP_MULWF);
  assign w_mul_ret = w_mul_done;

  // multiplier sequencing state
  always_ff @(posedge clk) begin
    if (rst) r_ms <= MS_IDLE;
    else     r_ms <= w_ms_n;
  end

  // next state, issue stall and multiplier start
  always_comb begin
    w_ms_n      = r_ms;
    w_rdy       = 1'b1;
    w_mul_start = 1'b0;
    unique case (r_ms)
      MS_IDLE, MS_DONE: begin
        w_ms_n = MS_IDLE;
        if (bus.op_valid && w_is_mul) begin
          w_mul_start = 1'b1;
          w_ms_n      = MS_MUL;
        end
      end
      MS_MUL: begin
        w_rdy = 1'b0;
        if (w_mul_done) w_ms_n = MS_DONE;
      end
      default: w_ms_n = MS_IDLE;
    endcase
  end

  // capture the finished product
  always_ff @(posedge clk) begin
    if (rst)             r_prod <= '0;
    else if (w_mul_done) r_prod <= w_mul_prod;
  end

  pic_alu_mul #(.DWIDTH(DWIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mul_start),
    .i_a     (r_w),
    .i_b     (w_f),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  assign bus.prod_o = r_prod;
`else
  assign w_rdy      = 1'b1;
  assign w_is_mul   = 1'b0;
  assign w_mul_ret  = 1'b0;
  assign bus.prod_o = '0;
`endif

  assign bus.op_ready           = w_rdy;
  assign bus.freg_o             = r_freg;
  assign bus.freg_wen           = r_wen;
  assign bus.res_valid          = r_rv;
  assign bus.skip               = r_skip;
  assign bus.w_o                = r_w;
  assign bus.status_carry       = r_c;
  assign bus.status_digit_carry = r_dc;
  assign bus.status_zero        = r_z;
endmodule

// File: tb/tb_pic_alu_gen2.sv
// tb_pic_alu_gen2: directed and randomized checks of pic_alu_gen2
// against an arithmetic reference model of W, STATUS and the pulses.
`timescale 1ns/1ps
module tb_pic_alu_gen2;
  import pic_params::*;

  localparam int M = 256;
  localparam int H = 16;

  bit   clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  int m_w, m_c, m_dc, m_z, m_freg;
  int e_wen, e_rv, e_skip;

  pic_alu_gen2_if #(.DWIDTH(8)) bus ();

  pic_alu_gen2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [4:0] op, input int f, input int lit,
                       input int b, input bit d, input bit v,
                       input bit sl, input logic [2:0] si);
    int r;
    bit ds, tow, tof, cw, dcw, zw, nc, ndc;
    r = 0; ds = 0; tow = 0; tof = 0;
    cw = 0; dcw = 0; zw = 0; nc = 0; ndc = 0;
    e_skip = 0;
    e_rv = v ? 1 : 0;
    if (v) begin
      case (op)
        OP_ADDWF: begin
          r = (m_w + f) % M; nc = (m_w + f) >= M;
          ndc = (m_w % H + f % H) >= H;
          ds = 1; cw = 1; dcw = 1; zw = 1;
        end
        OP_SUBWF: begin
          r = (f - m_w + M) % M; nc = f >= m_w;
          ndc = (f % H) >= (m_w % H);
          ds = 1; cw = 1; dcw = 1; zw = 1;
        end
        OP_ANDWF: begin r = m_w & f; ds = 1; zw = 1; end
        OP_IORWF: begin r = m_w | f; ds = 1; zw = 1; end
        OP_XORWF: begin r = m_w ^ f; ds = 1; zw = 1; end
        OP_COMF:  begin r = M - 1 - f; ds = 1; zw = 1; end
        OP_DECF:  begin r = (f + M - 1) % M; ds = 1; zw = 1; end
        OP_INCF:  begin r = (f + 1) % M; ds = 1; zw = 1; end
        OP_MOVF:  begin r = f; ds = 1; zw = 1; end
        OP_DECFSZ: begin
          r = (f + M - 1) % M; ds = 1; e_skip = (r == 0) ? 1 : 0;
        end
        OP_INCFSZ: begin
          r = (f + 1) % M; ds = 1; e_skip = (r == 0) ? 1 : 0;
        end
        OP_RLF: begin
          r = (f * 2 + m_c) % M; nc = f >= M / 2; cw = 1; ds = 1;
        end
        OP_RRF: begin
          r = f / 2 + m_c * (M / 2); nc = (f % 2) == 1; cw = 1; ds = 1;
        end
        OP_SWAPF: begin r = (f % H) * H + f / H; ds = 1; end
        OP_CLRF:  begin r = 0; tof = 1; zw = 1; end
        OP_CLRW:  begin r = 0; tow = 1; zw = 1; end
        OP_MOVWF: begin r = m_w; tof = 1; end
        OP_BCF: begin
          r = (((f >> b) % 2) == 1) ? f - (1 << b) : f; tof = 1;
        end
        OP_BSF: begin
          r = (((f >> b) % 2) == 1) ? f : f + (1 << b); tof = 1;
        end
        OP_BTFSC: e_skip = (((f >> b) % 2) == 0) ? 1 : 0;
        OP_BTFSS: e_skip = (((f >> b) % 2) == 1) ? 1 : 0;
        OP_ANDLW: begin r = m_w & lit; tow = 1; zw = 1; end
        OP_IORLW: begin r = m_w | lit; tow = 1; zw = 1; end
        OP_XORLW: begin r = m_w ^ lit; tow = 1; zw = 1; end
        OP_MOVLW: begin r = lit; tow = 1; end
        default: ;
      endcase
      if (ds) begin
        if (d) tof = 1;
        else   tow = 1;
      end
    end
    if (sl) begin
      m_c = int'(si[0]); m_dc = int'(si[1]); m_z = int'(si[2]);
    end
    if (cw)  m_c  = nc ? 1 : 0;
    if (dcw) m_dc = ndc ? 1 : 0;
    if (zw)  m_z  = (r == 0) ? 1 : 0;
    if (tow) m_w = r;
    if (tof) m_freg = r;
    e_wen = tof ? 1 : 0;
  endtask

  task automatic step(input logic [4:0] op, input int f, input int lit,
                      input int b, input bit d, input bit v,
                      input bit sl, input logic [2:0] si);
    @(negedge clk);
    bus.op_valid        = v;
    bus.alu_instruction = op;
    bus.freg_i          = f[7:0];
    bus.literal_value   = lit[7:0];
    bus.bit_num         = b[2:0];
    bus.dest_bit        = d;
    bus.status_load     = sl;
    bus.status_i        = si;
    @(posedge clk);
    #1;
    bus.op_valid    = 1'b0;
    bus.status_load = 1'b0;
    model(op, f, lit, b, d, v, sl, si);
  endtask

  task automatic model_reset();
    m_w = 0; m_c = 0; m_dc = 0; m_z = 0; m_freg = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.op_valid = 1'b1;
    bus.alu_instruction = OP_MOVLW;
    bus.literal_value = 8'h55;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++; if (bus.w_o !== 8'h00) begin n_fail++; $display("FAIL rst_w got %h want 00", bus.w_o); end
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
    n_chk++; if (bus.freg_o !== 8'h00) begin n_fail++; $display("FAIL rst_freg got %h want 00", bus.freg_o); end
    n_chk++; if ({bus.freg_wen, bus.res_valid, bus.skip} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got %b want 000", {bus.freg_wen, bus.res_valid, bus.skip}); end
    n_chk++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.op_ready); end
    n_chk++; if (bus.prod_o !== 16'h0000) begin n_fail++; $display("FAIL rst_prod got %h want 0000", bus.prod_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_add_sub();
    step(OP_MOVLW, 0, 'h0F, 0, 0, 1, 0, 3'b000);
    step(OP_ADDWF, 'h01, 0, 0, 0, 1, 0, 3'b000);
    n_chk++; if (bus.w_o !== 8'h10) begin n_fail++; $display("FAIL addwf_w got %h want 10", bus.w_o); end
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b010) begin n_fail++; $display("FAIL addwf_flags got %b want 010", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
    n_chk++; if (bus.freg_wen !== 1'b0) begin n_fail++; $display("FAIL addwf_wen got %b want 0", bus.freg_wen); end
    step(OP_MOVLW, 0, 'h01, 0, 0, 1, 0, 3'b000);
    step(OP_SUBWF, 'h01, 0, 0, 1, 1, 0, 3'b000);
    n_chk++; if ({bus.freg_wen, bus.freg_o} !== 9'h100) begin n_fail++; $display("FAIL subwf_eq_f got %b/%h want 1/00", bus.freg_wen, bus.freg_o); end
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b111) begin n_fail++; $display("FAIL subwf_eq_flags got %b want 111", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
    step(OP_MOVLW, 0, 'h02, 0, 0, 1, 0, 3'b000);
    step(OP_SUBWF, 'h01, 0, 0, 0, 1, 0, 3'b000);
    n_chk++; if (bus.w_o !== 8'hFF) begin n_fail++; $display("FAIL subwf_borrow_w got %h want ff", bus.w_o); end
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b000) begin n_fail++; $display("FAIL subwf_borrow_flags got %b want 000", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
  endtask

  task automatic test_rotate_skip();
    step(OP_NOP, 0, 0, 0, 0, 0, 1, 3'b001);
    step(OP_RRF, 'h02, 0, 0, 1, 1, 0, 3'b000);
    n_chk++; if (bus.freg_o !== 8'h81) begin n_fail++; $display("FAIL rrf_f got %h want 81", bus.freg_o); end
    n_chk++; if (bus.status_carry !== 1'b0) begin n_fail++; $display("FAIL rrf_c got %b want 0", bus.status_carry); end
    step(OP_DECFSZ, 'h01, 0, 0, 0, 1, 0, 3'b000);
    n_chk++; if (bus.skip !== 1'b1) begin n_fail++; $display("FAIL decfsz_skip got %b want 1", bus.skip); end
    n_chk++; if (bus.status_zero !== 1'b0) begin n_fail++; $display("FAIL decfsz_z got %b want 0", bus.status_zero); end
  endtask

  task automatic test_status_load();
    step(OP_MOVLW, 0, 'hFF, 0, 0, 1, 0, 3'b000);
    step(OP_ANDLW, 0, 'h0F, 0, 0, 1, 1, 3'b111);
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b011) begin n_fail++; $display("FAIL sload_andlw got %b want 011", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
    n_chk++; if (bus.w_o !== 8'h0F) begin n_fail++; $display("FAIL sload_w got %h want 0f", bus.w_o); end
  endtask

  task automatic test_back_to_back();
    step(OP_MOVLW, 0, 'hFE, 0, 0, 1, 0, 3'b000);
    step(OP_ADDWF, 'h01, 0, 0, 0, 1, 0, 3'b000);
    n_chk++; if ({bus.status_carry, bus.w_o} !== 9'h0FF) begin n_fail++; $display("FAIL b2b_1 got %b/%h want 0/ff", bus.status_carry, bus.w_o); end
    step(OP_ADDWF, 'h01, 0, 0, 0, 1, 0, 3'b000);
    n_chk++; if (bus.w_o !== 8'h00) begin n_fail++; $display("FAIL b2b_2_w got %h want 00", bus.w_o); end
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b111) begin n_fail++; $display("FAIL b2b_2_flags got %b want 111", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
  endtask

  task automatic test_idle_pulses();
    step(OP_BSF, 'h00, 0, 7, 0, 1, 0, 3'b000);
    n_chk++; if ({bus.freg_wen, bus.freg_o} !== 9'h180) begin n_fail++; $display("FAIL bsf got %b/%h want 1/80", bus.freg_wen, bus.freg_o); end
    step(OP_BSF, 'h00, 0, 7, 0, 0, 0, 3'b000);
    n_chk++; if ({bus.freg_wen, bus.res_valid, bus.skip} !== 3'b000) begin n_fail++; $display("FAIL idle_pulses got %b want 000", {bus.freg_wen, bus.res_valid, bus.skip}); end
    n_chk++; if (bus.freg_o !== 8'h80) begin n_fail++; $display("FAIL idle_hold got %h want 80", bus.freg_o); end
    step(OP_BTFSS, 'h80, 0, 7, 1, 1, 0, 3'b000);
    n_chk++; if ({bus.freg_wen, bus.res_valid, bus.skip} !== 3'b011) begin n_fail++; $display("FAIL btfss got %b want 011", {bus.freg_wen, bus.res_valid, bus.skip}); end
  endtask

`ifdef PIC_ALU_MULT_EN
  task automatic test_mul();
    int exp_p;
    step(OP_MOVLW, 0, 'hFF, 0, 0, 1, 0, 3'b000);
    exp_p = m_w * 255;
    step(OP_MULWF, 'hFF, 0, 0, 0, 1, 0, 3'b000);
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy%0d got %b want 0", i, bus.op_ready); end
      if (i == 3) begin
        @(negedge clk);
        bus.status_load = 1'b1; bus.status_i = 3'b111;
        @(posedge clk); #1;
        bus.status_load = 1'b0;
        m_c = 1; m_dc = 1; m_z = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    n_chk++; if ({bus.op_ready, bus.res_valid} !== 2'b11) begin n_fail++; $display("FAIL mul_done got %b want 11", {bus.op_ready, bus.res_valid}); end
    n_chk++; if (bus.prod_o !== exp_p[15:0]) begin n_fail++; $display("FAIL mul_prod got %h want %h", bus.prod_o, exp_p[15:0]); end
    n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== 3'b111) begin n_fail++; $display("FAIL mul_flags got %b want 111", {bus.status_zero, bus.status_digit_carry, bus.status_carry}); end
    @(posedge clk); #1;
    n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mul_rv_pulse got %b want 0", bus.res_valid); end
    step(OP_MULWF, 'h03, 0, 0, 0, 1, 0, 3'b000);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({bus.op_ready, bus.prod_o} !== 17'h10000) begin n_fail++; $display("FAIL mul_abort got %b/%h want 1/0000", bus.op_ready, bus.prod_o); end
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask
`else
  task automatic test_mulwf_unlisted();
    int w0;
    w0 = m_w;
    step(OP_MULWF, 'h33, 0, 0, 1, 1, 0, 3'b000);
    n_chk++; if ({bus.op_ready, bus.res_valid, bus.freg_wen} !== 3'b110) begin n_fail++; $display("FAIL mulwf_nop got %b want 110", {bus.op_ready, bus.res_valid, bus.freg_wen}); end
    n_chk++; if ({bus.w_o, bus.prod_o} !== {w0[7:0], 16'h0000}) begin n_fail++; $display("FAIL mulwf_state got %h/%h want %h/0000", bus.w_o, bus.prod_o, w0[7:0]); end
  endtask
`endif

  task automatic test_random();
    logic [4:0] op;
    logic [2:0] si;
    bit v, sl, d;
    for (int n = 0; n < 400; n++) begin
      do begin
        op = 5'($urandom_range(0, 31));
      end while (op == OP_MULWF && `ifdef PIC_ALU_MULT_EN 1'b1 `else 1'b0 `endif);
      v  = ($urandom_range(0, 9) != 0);
      sl = ($urandom_range(0, 3) == 0);
      d  = 1'($urandom_range(0, 1));
      si = 3'($urandom_range(0, 7));
      step(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 7)), d, v, sl, si);
      n_chk++; if (bus.w_o !== m_w[7:0]) begin n_fail++; $display("FAIL rnd%0d_w op=%0d got %h want %h", n, op, bus.w_o, m_w[7:0]); end
      n_chk++; if (bus.freg_o !== m_freg[7:0]) begin n_fail++; $display("FAIL rnd%0d_freg op=%0d got %h want %h", n, op, bus.freg_o, m_freg[7:0]); end
      n_chk++; if ({bus.status_zero, bus.status_digit_carry, bus.status_carry} !== {m_z[0], m_dc[0], m_c[0]}) begin n_fail++; $display("FAIL rnd%0d_flags op=%0d got %b want %b", n, op, {bus.status_zero, bus.status_digit_carry, bus.status_carry}, {m_z[0], m_dc[0], m_c[0]}); end
      n_chk++; if ({bus.freg_wen, bus.res_valid, bus.skip} !== {e_wen[0], e_rv[0], e_skip[0]}) begin n_fail++; $display("FAIL rnd%0d_pulses op=%0d got %b want %b", n, op, {bus.freg_wen, bus.res_valid, bus.skip}, {e_wen[0], e_rv[0], e_skip[0]}); end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.op_valid = 1'b0;
    bus.alu_instruction = OP_NOP;
    bus.bit_num = '0;
    bus.literal_value = '0;
    bus.dest_bit = 1'b0;
    bus.freg_i = '0;
    bus.status_load = 1'b0;
    bus.status_i = '0;
    model_reset();
    test_reset();
    test_add_sub();
    test_rotate_skip();
    test_status_load();
    test_back_to_back();
    test_idle_pulses();
`ifdef PIC_ALU_MULT_EN
    test_mul();
`else
    test_mulwf_unlisted();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
